fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter sharing the single write port of the async FIFO among NUM_REQ requesters in the write-clock domain.
- Grants are packet-locked: a winner keeps the port until it sends its last beat or hits MAX_BURST beats, then arbitration rotates.
- Drives the FIFO's wr_enable/write_data pair and obeys full.
- Sits directly in front of the FIFO write side; the read side is untouched.

---
 rtl/fifo_wr_arbiter_if.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 147 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ requesters, the round-robin arbiter and the
// async FIFO write port.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic                          flush;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          full;
    logic                          wr_enable;
    logic [DATA_WIDTH-1:0]         write_data;
    logic [NUM_REQ-1:0]            grant;
    logic                          busy;

    modport slave (
        input  flush, req_valid, req_last, req_data, full,
        output req_ready, wr_enable, write_data, grant, busy
    );

    modport master (
        output flush, req_valid, req_last, req_data, full,
        input  req_ready, wr_enable, write_data, grant, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter for the async FIFO write port.
// Define FIFO_WR_ARB_STATS_EN to add saturating per-requester beat counters.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                    w_clk,
    input  logic                    wreset,
    fifo_wr_arbiter_if.slave        bus
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]   beat_count
`endif
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_found;
    logic [NUM_REQ-1:0]   ready;
    logic                 wr_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic                 release_beat;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum -= NUM_REQ;
        return IDX_W'(sum);
    endfunction

    // First valid requester at or above rr_ptr, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && bus.req_valid[wrap_add(rr_ptr_q, i)]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(rr_ptr_q, i);
            end
        end
    end

    always_ff @(posedge w_clk or posedge wreset) begin
        if (wreset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign release_beat = wr_en &
        (bus.req_last[owner_q] | (beat_cnt_q == CNT_W'(MAX_BURST - 1)));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        if (bus.flush) begin
            // rr_ptr is left alone so the aborted owner wins the next round
            state_d    = IDLE;
            grant_d    = '0;
            beat_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        state_d    = LOCK;
                        grant_d    = NUM_REQ'(1) << win_idx;
                        owner_d    = win_idx;
                        beat_cnt_d = '0;
                    end
                end
                LOCK: begin
                    if (release_beat) begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        beat_cnt_d = '0;
                        rr_ptr_d   = wrap_add(owner_q, 1);
                    end else if (wr_en) begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ready = '0;
        wr_en = 1'b0;
        wdata = '0;
        if (state_q == LOCK) begin
            wdata = bus.req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
            if (!bus.flush) begin
                ready[owner_q] = ~bus.full;
                wr_en          = bus.req_valid[owner_q] & ~bus.full;
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.wr_enable  = wr_en;
    assign bus.write_data = wdata;
    assign bus.grant      = grant_q;
    assign bus.busy       = (state_q == LOCK);

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stats_q [NUM_REQ];

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    always_ff @(posedge w_clk or posedge wreset) begin
        if (wreset) begin
            for (int i = 0; i < NUM_REQ; i++) stats_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (wr_en && owner_q == IDX_W'(i)) stats_q[i] <= sat_inc16(stats_q[i]);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
        assign beat_count[gi*16 +: 16] = stats_q[gi];
    end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, round-robin order, burst cap,
// backpressure, flush and (when enabled) the saturating beat counters.
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 16;

    logic w_clk  = 1'b0;
    logic wreset = 1'b1;
    int   total  = 0;
    int   bad    = 0;
    logic [DW-1:0] wlog[$];

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
    logic [NR*16-1:0] beat_count;
    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .w_clk(w_clk), .wreset(wreset), .bus(bus), .beat_count(beat_count));
`else
    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .w_clk(w_clk), .wreset(wreset), .bus(bus));
`endif

    always #5 w_clk = ~w_clk;

    always @(negedge w_clk) if (bus.wr_enable) wlog.push_back(bus.write_data);

    task automatic step;
        @(posedge w_clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic l, input logic [DW-1:0] d);
        bus.req_valid[i]       = v;
        bus.req_last[i]        = l;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic clear_inputs;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.full      = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic apply_reset;
        clear_inputs();
        wreset = 1'b1;
        step();
        step();
        wreset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        clear_inputs();
        bus.req_valid = '1;
        wreset = 1'b1;
        #1;
        total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL rst_grant: got %b want 0000", bus.grant); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        total++; if (bus.wr_enable !== 1'b0) begin bad++; $display("FAIL rst_wr_enable: got %b want 0", bus.wr_enable); end
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready: got %b want 0000", bus.req_ready); end
        total++; if (bus.write_data !== 8'h00) begin bad++; $display("FAIL rst_write_data: got %h want 00", bus.write_data); end
        clear_inputs();
        step();
        wreset = 1'b0;
        set_req(1, 1'b1, 1'b0, 8'h21);
        step();
        total++; if (bus.grant !== 4'b0010) begin bad++; $display("FAIL rst_pre_grant: got %b want 0010", bus.grant); end
        total++; if (bus.wr_enable !== 1'b1 || bus.write_data !== 8'h21) begin
            bad++; $display("FAIL rst_pre_beat: got en=%b data=%h want en=1 data=21", bus.wr_enable, bus.write_data); end
        step();
        #1;
        wreset = 1'b1;
        #1;
        total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL rst_async_grant: got %b want 0000", bus.grant); end
        total++; if (bus.wr_enable !== 1'b0) begin bad++; $display("FAIL rst_async_wr_enable: got %b want 0", bus.wr_enable); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy: got %b want 0", bus.busy); end
        set_req(0, 1'b1, 1'b0, 8'h01);
        wreset = 1'b0;
        step();
        total++; if (bus.grant !== 4'b0001) begin bad++; $display("FAIL rst_first_grant: got %b want 0001", bus.grant); end
    endtask

    task automatic test_round_robin;
        logic [NR-1:0] exp_g [9];
        exp_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        apply_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, DW'(8'hA0 + i));
        wlog.delete();
        for (int k = 0; k < 9; k++) begin
            step();
            total++; if (bus.grant !== exp_g[k]) begin
                bad++; $display("FAIL rr_grant[%0d]: got %b want %b", k, bus.grant, exp_g[k]); end
        end
        total++; if (wlog.size() != 4) begin bad++; $display("FAIL rr_write_count: got %0d want 4", wlog.size()); end
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            total++; if (wlog[i] !== DW'(8'hA0 + i)) begin
                bad++; $display("FAIL rr_data[%0d]: got %h want %h", i, wlog[i], DW'(8'hA0 + i)); end
        end
    endtask

    task automatic test_burst_cap;
        int n1;
        apply_reset();
        set_req(1, 1'b1, 1'b0, 8'h11);
        set_req(2, 1'b1, 1'b1, 8'h55);
        wlog.delete();
        n1 = 0;
        for (int k = 0; k < MB; k++) begin
            step();
            if (bus.grant === 4'b0010 && bus.wr_enable === 1'b1) n1++;
        end
        total++; if (n1 != MB) begin bad++; $display("FAIL cap_req1_beats: got %0d want %0d", n1, MB); end
        step();
        total++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL cap_bubble: got grant=%b busy=%b want 0000/0", bus.grant, bus.busy); end
        step();
        total++; if (bus.grant !== 4'b0100) begin bad++; $display("FAIL cap_req2_grant: got %b want 0100", bus.grant); end
        step();
        set_req(2, 1'b0, 1'b0, 8'h00);
        total++; if (wlog.size() != MB + 1) begin bad++; $display("FAIL cap_write_count: got %0d want %0d", wlog.size(), MB + 1); end
        else begin
            total++; if (wlog[MB] !== 8'h55 || wlog[0] !== 8'h11) begin
                bad++; $display("FAIL cap_data: got %h/%h want 11/55", wlog[0], wlog[MB]); end
        end
        step();
        total++; if (bus.grant !== 4'b0010) begin bad++; $display("FAIL cap_req1_regrant: got %b want 0010", bus.grant); end
    endtask

    task automatic test_backpressure;
        logic acc;
        int   b;
        apply_reset();
        wlog.delete();
        b = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            bus.full = (cyc >= 4 && cyc <= 8);
            if (b < 8) set_req(0, 1'b1, (b == 7), DW'(8'h30 + b));
            else       set_req(0, 1'b0, 1'b0, 8'h00);
            #1;
            if (bus.full) begin
                total++; if (bus.wr_enable !== 1'b0) begin
                    bad++; $display("FAIL bp_wr_enable[%0d]: got %b want 0", cyc, bus.wr_enable); end
                total++; if (int'(dut.beat_cnt_q) != 3) begin
                    bad++; $display("FAIL bp_beat_cnt[%0d]: got %0d want 3", cyc, dut.beat_cnt_q); end
            end
            acc = bus.req_valid[0] & bus.req_ready[0];
            step();
            if (acc) b++;
        end
        total++; if (wlog.size() != 8) begin bad++; $display("FAIL bp_write_count: got %0d want 8", wlog.size()); end
        for (int i = 0; i < 8 && i < wlog.size(); i++) begin
            total++; if (wlog[i] !== DW'(8'h30 + i)) begin
                bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, wlog[i], DW'(8'h30 + i)); end
        end
    endtask

    task automatic test_flush;
        apply_reset();
        set_req(2, 1'b1, 1'b1, 8'h22);
        step();
        total++; if (bus.grant !== 4'b0100) begin bad++; $display("FAIL fl_setup_grant: got %b want 0100", bus.grant); end
        step();
        set_req(2, 1'b0, 1'b0, 8'h00);
        set_req(3, 1'b1, 1'b0, 8'hC3);
        set_req(0, 1'b1, 1'b0, 8'h0A);
        wlog.delete();
        step();
        total++; if (bus.grant !== 4'b1000) begin bad++; $display("FAIL fl_req3_grant: got %b want 1000", bus.grant); end
        step();
        step();
        bus.flush = 1'b1;
        #1;
        total++; if (bus.wr_enable !== 1'b0) begin bad++; $display("FAIL fl_wr_enable: got %b want 0", bus.wr_enable); end
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL fl_req_ready: got %b want 0000", bus.req_ready); end
        step();
        bus.flush = 1'b0;
        #1;
        total++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL fl_idle: got grant=%b busy=%b want 0000/0", bus.grant, bus.busy); end
        step();
        total++; if (bus.grant !== 4'b1000) begin bad++; $display("FAIL fl_regrant: got %b want 1000", bus.grant); end
        total++; if (wlog.size() != 2) begin bad++; $display("FAIL fl_write_count: got %0d want 2", wlog.size()); end
    endtask

`ifdef FIFO_WR_ARB_STATS_EN
    task automatic test_stats;
        apply_reset();
        set_req(0, 1'b1, 1'b0, 8'h01);
        repeat (75000) step();
        total++; if (beat_count[15:0] !== 16'hFFFF) begin
            bad++; $display("FAIL st_req0: got %h want ffff", beat_count[15:0]); end
        total++; if (beat_count[NR*16-1:16] !== '0) begin
            bad++; $display("FAIL st_others: got %h want 0", beat_count[NR*16-1:16]); end
    endtask
`endif

    initial begin
        clear_inputs();
        test_reset();
        test_round_robin();
        test_burst_cap();
        test_backpressure();
        test_flush();
`ifdef FIFO_WR_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
